// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller is the master: it consumes opcode/flags/handshake and drives the strobes.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic [1:0]       ALUop;
    logic             alusrc;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic             regwrite;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output ALUop, alusrc, ir_write, pc_write, pc_src,
               memread, memwrite, memtoreg, regwrite, illegal, state, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ALUop, alusrc, ir_write, pc_write, pc_src,
               memread, memwrite, memtoreg, regwrite, illegal, state, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle CPU controller (FETCH/DECODE/EXEC/MEM/WB) with a
// retired-instruction counter; the instruction class is latched at DECODE.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    multicycle_ctrl_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH
    } cls_t;

    logic [2:0]       cur, nxt;
    cls_t             cls, dec_cls;
    logic [CNT_W-1:0] retired;
    logic             retire;

    always_comb begin
        case (bus.opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            default:    dec_cls = C_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    // Class is captured once so a changing opcode cannot disturb EXEC/MEM/WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls     <= C_NONE;
            retired <= '0;
        end else begin
            if (cur == S_DECODE) cls <= dec_cls;
            if (retire)          retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        nxt    = S_FETCH;
        retire = 1'b0;
        case (cur)
            S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: nxt = (dec_cls != C_NONE) ? S_EXEC : S_FETCH;
            S_EXEC: begin
                case (cls)
                    C_R, C_I:         nxt = S_WB;
                    C_LOAD, C_STORE:  nxt = S_MEM;
                    C_BRANCH: begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end
                    default:          nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!bus.mem_ready)      nxt = S_MEM;
                else if (cls == C_LOAD)  nxt = S_WB;
                else begin
                    nxt    = S_FETCH;
                    retire = (cls == C_STORE);
                end
            end
            S_WB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default:  nxt = S_FETCH;
        endcase
    end

    always_comb begin
        bus.ALUop    = 2'b00;
        bus.alusrc   = 1'b0;
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_src   = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.illegal  = 1'b0;
        case (cur)
            S_FETCH: begin
                // Strobes are held off while reset is asserted.
                bus.memread  = 1'b1;
                bus.ir_write = bus.mem_ready & ~rst;
                bus.pc_write = bus.mem_ready & ~rst;
            end
            S_DECODE: bus.illegal = (dec_cls == C_NONE);
            S_EXEC: begin
                case (cls)
                    C_R: bus.ALUop = 2'b10;
                    C_I: begin
                        bus.ALUop  = 2'b11;
                        bus.alusrc = 1'b1;
                    end
                    C_LOAD, C_STORE: bus.alusrc = 1'b1;
                    C_BRANCH: begin
                        bus.ALUop    = 2'b01;
                        bus.pc_write = bus.zero;
                        bus.pc_src   = bus.zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.alusrc   = 1'b1;
                bus.memread  = (cls == C_LOAD);
                bus.memwrite = (cls == C_STORE);
            end
            S_WB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = (cls == C_LOAD);
            end
            default: ;
        endcase
    end

    assign bus.state   = cur;
    assign bus.retired = retired;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed latency table, randomized instruction
// stream against a phase-list reference model, and reset corner sequences.
module tb_multicycle_ctrl;
    localparam int CNT_W = 32;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();
    multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] aluop;
        logic alusrc, ir_write, pc_write, pc_src;
        logic memread, memwrite, memtoreg, regwrite, illegal;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        bit         z;
        int         fw;
        int         mw;
        int         lat;
    } vec_t;

    int n_pass = 0;
    int n_chk  = 0;
    logic [CNT_W-1:0] model_ret = '0;

    // Classes: 0 illegal, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BRANCH
    function automatic int cls_of(input logic [6:0] op);
        if (op == OP_R)  return 1;
        if (op == OP_I)  return 2;
        if (op == OP_LD) return 3;
        if (op == OP_ST) return 4;
        if (op == OP_BR) return 5;
        return 0;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{bus.state, bus.ALUop, bus.alusrc, bus.ir_write, bus.pc_write, bus.pc_src,
              bus.memread, bus.memwrite, bus.memtoreg, bus.regwrite, bus.illegal};
        return o;
    endfunction

    // Expected outputs from the per-phase control table.
    function automatic obs_t ref_out(input int ph, input int c, input bit rdy, input bit z);
        obs_t o = '0;
        o.st = 3'(ph);
        case (ph)
            0: begin
                o.memread  = 1'b1;
                o.ir_write = rdy;
                o.pc_write = rdy;
            end
            1: o.illegal = (c == 0);
            2: begin
                if (c == 1) o.aluop = 2'b10;
                if (c == 2) begin o.aluop = 2'b11; o.alusrc = 1'b1; end
                if (c == 3 || c == 4) o.alusrc = 1'b1;
                if (c == 5) begin o.aluop = 2'b01; o.pc_write = z; o.pc_src = z; end
            end
            3: begin
                o.alusrc   = 1'b1;
                o.memread  = (c == 3);
                o.memwrite = (c == 4);
            end
            4: begin
                o.regwrite = 1'b1;
                o.memtoreg = (c == 3);
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Runs one instruction: fw FETCH wait cycles, mw MEM wait cycles.
    task automatic run_instr(input logic [6:0] op, input bit z, input int fw, input int mw,
                             output int lat);
        int c;
        int ph[$];
        bit rd[$];
        obs_t o;
        c = cls_of(op);
        for (int i = 0; i <= fw; i++) begin ph.push_back(0); rd.push_back(i == fw); end
        ph.push_back(1); rd.push_back(1'($urandom));
        if (c != 0) begin ph.push_back(2); rd.push_back(1'($urandom)); end
        if (c == 3 || c == 4)
            for (int i = 0; i <= mw; i++) begin ph.push_back(3); rd.push_back(i == mw); end
        if (c >= 1 && c <= 3) begin ph.push_back(4); rd.push_back(1'($urandom)); end
        lat = fw + 1;
        for (int k = 0; k < ph.size(); k++) begin
            bus.mem_ready = rd[k];
            bus.zero      = (ph[k] == 2) ? z : 1'($urandom);
            bus.opcode    = (ph[k] == 1) ? op : 7'($urandom);
            @(negedge clk);
            o = sample();
            check($sformatf("outputs op=%b phase=%0d", op, ph[k]), 64'(o),
                  64'(ref_out(ph[k], c, rd[k], bus.zero)));
            check("retired", 64'(bus.retired), 64'(model_ret));
            if (o.st != 3'd0) lat++;
            @(posedge clk); #1;
        end
        if (c != 0) model_ret = model_ret + CNT_W'(1);
    endtask

    vec_t tbl[10];
    int   lat;
    obs_t o;
    logic [6:0] ops[6];

    initial begin
        tbl[0] = '{OP_R,  1'b0, 2, 0, 6};
        tbl[1] = '{OP_R,  1'b0, 0, 0, 4};
        tbl[2] = '{OP_I,  1'b1, 0, 0, 4};
        tbl[3] = '{OP_LD, 1'b0, 0, 2, 7};
        tbl[4] = '{OP_LD, 1'b1, 0, 0, 5};
        tbl[5] = '{OP_ST, 1'b0, 0, 0, 4};
        tbl[6] = '{OP_ST, 1'b0, 1, 1, 6};
        tbl[7] = '{OP_BR, 1'b1, 0, 0, 3};
        tbl[8] = '{OP_BR, 1'b0, 0, 0, 3};
        tbl[9] = '{OP_XX, 1'b0, 0, 0, 2};
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_XX};

        rst = 1'b1;
        bus.opcode = OP_R;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("reset outputs", 64'(sample()), 64'(ref_out(0, 0, 1'b0, 1'b0)));
        check("reset retired", 64'(bus.retired), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, lat);
            check($sformatf("latency vec%0d", i), 64'(lat), 64'(tbl[i].lat));
        end

        for (int n = 0; n < 200; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            run_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), lat);
        end

        // STORE stalled in MEM, then reset mid-cycle.
        bus.opcode = OP_ST;
        bus.mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        o = sample();
        check("store held in MEM state", 64'(o.st), 64'd3);
        check("store memwrite", 64'(o.memwrite), 64'd1);
        check("retired before abort", 64'(bus.retired), 64'(model_ret));
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("async reset outputs", 64'(sample()), 64'(ref_out(0, 0, 1'b0, 1'b0)));
        check("async reset retired", 64'(bus.retired), 64'd0);
        @(negedge clk);
        check("reset rest of cycle", 64'(sample()), 64'(ref_out(0, 0, 1'b0, 1'b0)));
        bus.mem_ready = 1'b0;
        rst = 1'b0;
        model_ret = '0;
        @(posedge clk); #1;
        check("hold FETCH without ready", 64'(bus.state), 64'd0);
        run_instr(OP_ST, 1'b0, 1, 0, lat);
        check("latency after reset", 64'(lat), 64'd5);
        run_instr(OP_R, 1'b0, 0, 0, lat);
        @(negedge clk);
        check("retired after recovery", 64'(bus.retired), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
